// File: rtl/session_pkg.sv
// Shared types and constants for the session controller: FSM state encoding
// (matching the st1 codes the timer sees, plus CHECK) and keypad control codes.
package session_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_SHOW  = 3'd2,
    ST_FAULT = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;

  // CHECK is reported to the timer as part of the entry phase.
  function automatic logic [1:0] st1_code(input state_e s);
    case (s)
      ST_IDLE:            st1_code = 2'd0;
      ST_ENTRY, ST_CHECK: st1_code = 2'd1;
      ST_SHOW:            st1_code = 2'd2;
      default:            st1_code = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/id_entry_buf.sv
// Keypad ID shift register: new digits enter the LS nibble, so the first digit
// typed ends up in the MS nibble once the buffer is full.
module id_entry_buf #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic                  clear,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   id_buf,
  output logic [2:0]            digit_cnt,
  output logic                  full
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] buf_q, buf_d;
  logic [2:0]   cnt_q, cnt_d;

  assign full      = (cnt_q == 3'(DIGITS));
  assign id_buf    = buf_q;
  assign digit_cnt = cnt_q;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (shift && !full) begin
      buf_d = {buf_q[W-5:0], digit};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/session_ctrl.sv
// Session controller: collects a keypad ID, checks it against ref_id with a
// retry limit, and sequences the timeout timer through st1 / tmr_rst_n.
module session_ctrl
  import session_pkg::*;
#(
  parameter int ID_DIGITS = 4,
  parameter int MAX_TRIES = 3,
  parameter int FAULT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   card_in,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  input  logic [4*ID_DIGITS-1:0] ref_id,
  input  logic                   time_max_id,
  input  logic                   time_max_exb,
  output logic [1:0]             st1,
  output logic                   id_typed,
  output logic                   id_err,
  output logic [2:0]             digit_cnt,
  output logic                   tmr_rst_n
);

  localparam int ATW = $clog2(MAX_TRIES + 1);
  localparam int FCW = (FAULT_CYC > 1) ? $clog2(FAULT_CYC) : 1;

  state_e           state_q, state_d;
  logic [ATW-1:0]   attempts_q, attempts_d;
  logic [FCW-1:0]   fault_cnt_q, fault_cnt_d;
  logic [1:0]       st1_q, st1_d;
  logic             id_typed_q, id_typed_d;
  logic             id_err_q, id_err_d;
  logic             tmr_rst_n_q, tmr_rst_n_d;

  logic                   buf_shift;
  logic                   buf_clear;
  logic                   buf_full;
  logic [4*ID_DIGITS-1:0] id_buf;

  id_entry_buf #(.DIGITS(ID_DIGITS)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .shift     (buf_shift),
    .clear     (buf_clear),
    .digit     (key_code),
    .id_buf    (id_buf),
    .digit_cnt (digit_cnt),
    .full      (buf_full)
  );

  always_comb begin
    state_d     = state_q;
    attempts_d  = attempts_q;
    fault_cnt_d = fault_cnt_q;
    id_typed_d  = 1'b0;
    id_err_d    = 1'b0;
    tmr_rst_n_d = 1'b1;
    buf_shift   = 1'b0;
    buf_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        buf_clear  = 1'b1;
        attempts_d = '0;
        if (card_in) state_d = ST_ENTRY;
      end
      ST_ENTRY: begin
        // The entry-window expiry wins over any key arriving in the same cycle.
        if (time_max_id) begin
          state_d     = ST_FAULT;
          fault_cnt_d = FCW'(FAULT_CYC - 1);
        end else if (key_valid) begin
          if (key_code <= 4'd9) begin
            buf_shift = 1'b1;
          end else if (key_code == KEY_CLR) begin
            buf_clear = 1'b1;
          end else if (key_code == KEY_ENT && buf_full) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (time_max_id) begin
          state_d     = ST_FAULT;
          fault_cnt_d = FCW'(FAULT_CYC - 1);
        end else if (id_buf == ref_id) begin
          state_d    = ST_SHOW;
          id_typed_d = 1'b1;
        end else begin
          id_err_d  = 1'b1;
          buf_clear = 1'b1;
          if (attempts_q != ATW'(MAX_TRIES)) attempts_d = attempts_q + 1'b1;
          if (int'(attempts_q) + 1 >= MAX_TRIES) begin
            state_d     = ST_FAULT;
            fault_cnt_d = FCW'(FAULT_CYC - 1);
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end
      ST_SHOW: begin
        if (time_max_exb) begin
          state_d     = ST_IDLE;
          tmr_rst_n_d = 1'b0;
        end
      end
      default: begin
        if (fault_cnt_q == '0) begin
          state_d     = ST_IDLE;
          tmr_rst_n_d = 1'b0;
        end else begin
          fault_cnt_d = fault_cnt_q - 1'b1;
        end
      end
    endcase

    // Registered from the next state so st1 moves together with state_q.
    st1_d = st1_code(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      attempts_q  <= '0;
      fault_cnt_q <= '0;
      st1_q       <= 2'd0;
      id_typed_q  <= 1'b0;
      id_err_q    <= 1'b0;
      tmr_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      attempts_q  <= attempts_d;
      fault_cnt_q <= fault_cnt_d;
      st1_q       <= st1_d;
      id_typed_q  <= id_typed_d;
      id_err_q    <= id_err_d;
      tmr_rst_n_q <= tmr_rst_n_d;
    end
  end

  assign st1       = st1_q;
  assign id_typed  = id_typed_q;
  assign id_err    = id_err_q;
  assign tmr_rst_n = tmr_rst_n_q;

endmodule

// File: doc/session_ctrl.md
# session_ctrl

Session controller on the initiating side of the timeout timer. Drives the timer's `st1` state code and `id_typed` strobe, collects a keypad ID, compares it against a reference ID and limits retries. Consumes the timer's `time_max_id` and `time_max_exb` expiries to abort or close the session, then clears the timer through `tmr_rst_n`.

## Interface
- `ID_DIGITS`, 4: number of BCD digits in an ID.
- `MAX_TRIES`, 3: wrong-ID attempts allowed before FAULT.
- `FAULT_CYC`, 16: cycles spent in FAULT before returning to IDLE.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `card_in`  in  1  session request; sampled only in IDLE.
- `key_valid`  in  1  one-cycle keypad strobe.
- `key_code`  in  4  0–9 digit, 4'hA clear, 4'hB enter, others ignored.
- `ref_id`  in  4*ID_DIGITS  expected ID; digit 0 in the MS nibble.
- `time_max_id`  in  1  ID-entry window expired (from timer).
- `time_max_exb`  in  1  exhibition window expired (from timer).
- `st1`  out  2  state code to timer: 0 idle, 1 entry/check, 2 show, 3 fault.
- `id_typed`  out  1  one-cycle pulse on a correct ID.
- `id_err`  out  1  one-cycle pulse on a wrong ID.
- `digit_cnt`  out  3  digits currently buffered.
- `tmr_rst_n`  out  1  active-low one-cycle clear to the timer.

## Operation
- States and `st1` codes: IDLE (0), ENTRY (1), CHECK (1), SHOW (2), FAULT (3).
- IDLE
  - `card_in` moves to ENTRY.
  - Clears the buffer, `digit_cnt` and the attempt counter.
- ENTRY, in priority order:
  - `time_max_id` moves to FAULT and overrides any key in the same cycle.
  - Digit with `digit_cnt` < ID_DIGITS shifts into the LS nibble; `digit_cnt` increments.
  - Digit with the buffer full is ignored.
  - Clear sets `digit_cnt` to 0.
  - Enter with `digit_cnt` == ID_DIGITS moves to CHECK; enter with fewer digits is ignored.
- CHECK (one cycle), in priority order:
  - `time_max_id` moves to FAULT.
  - Buffer == `ref_id`: move to SHOW and pulse `id_typed`.
  - Mismatch: attempts++, pulse `id_err`, clear the buffer. If attempts reaches MAX_TRIES, move to FAULT; otherwise return to ENTRY.
- SHOW
  - `time_max_exb` moves to IDLE and pulses `tmr_rst_n` low.
  - Keys, `card_in` and `time_max_id` are ignored.
- FAULT
  - Down-counter loads FAULT_CYC-1 on entry.
  - At 0, move to IDLE and pulse `tmr_rst_n` low.
  - All inputs are ignored.
- `rst` overrides everything, mid-session included.
- Attempt counter width is $clog2(MAX_TRIES+1); it never wraps.

## Timing
- Reset values: `st1`=0, `id_typed`=0, `id_err`=0, `digit_cnt`=0, `tmr_rst_n`=1, buffer 0, attempts 0.
- All outputs are registered.
- Key latency: `key_valid` at cycle n updates `digit_cnt` at n+1.
- Enter at n puts the FSM in CHECK at n+1. At n+2 either:
  - `st1`=2 with `id_typed`=1 for exactly one cycle, or
  - `id_err`=1 for one cycle with `st1`=1 (retry) or `st1`=3 (fault).
- `st1` changes in the same cycle as the state register. The timer samples it on the falling edge, so it is stable half a cycle before use.
- Session close: expiry at n gives `tmr_rst_n`=0 and `st1`=0 during n+1; `tmr_rst_n`=1 at n+2.
- Back-to-back: `card_in` held high re-enters ENTRY at n+2, the first IDLE cycle.
- Fault duration: exactly FAULT_CYC cycles with `st1`=3.

## Structure
- Shared package `session_pkg` holds:
  - State encodings (equal to the `st1` codes, plus CHECK).
  - Key constants KEY_CLR=4'hA and KEY_ENT=4'hB.
- Sub-module `id_entry_buf` holds the shift register and `digit_cnt`, with inputs shift, clear and digit, and outputs buf and full.
- FSM, attempt counter and fault counter stay in `session_ctrl`.

## Test plan
- Correct ID: `ref_id`=16'h1234, card, keys 1,2,3,4, enter → `id_typed` one cycle at enter+2; `st1` 1→2; `id_err` never high.
- Wrong ID: keys 1,2,3,5, enter → `id_err` pulse, `st1`=1, `digit_cnt`=0. Third wrong entry → `st1`=3 for 16 cycles, then `tmr_rst_n` low one cycle, `st1`=0.
- Buffer limits:
  - Fifth digit ignored (`digit_cnt` stays 4).
  - Enter after 3 digits ignored.
  - Clear then 4,3,2,1 → buffer 16'h4321.
- Entry timeout: `time_max_id` in the same cycle as key_valid=enter → FAULT; no `id_typed`.
- Exhibition close: in SHOW, `time_max_exb` pulse → `st1`=0 and `tmr_rst_n`=0 next cycle; keys during SHOW leave `digit_cnt` unchanged.
- Reset mid-session: `rst` asserted in SHOW and in FAULT → all outputs at reset values next cycle; attempt count cleared.
